ahb_ext_mem_sub: RTL and testbench

AHB_EXT_MEM_SUB -- requirements
Module: ahb_ext_mem_sub

---
 rtl/ahb_ext_mem_sub.sv | 163 ++++++++++++++++
 tb/tb_ahb_ext_mem_sub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ext_mem_sub.sv
// Purpose : AHB-Lite subordinate with a byte-strobed SRAM array behind a fixed wait-state timer.
// Latency : WAIT low-HREADYOUT cycles then one DONE cycle per OKAY transfer; errors take two cycles.
// Backpr. : new address phase is only sampled with HREADY high; bus changes during wait/ERR1 are ignored.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   address phase (sampled when HSEL & HREADY & HTRANS[1])
//   HWRITE, HSIZE, HBURST  (HBURST is ignored)
//   HREADY                 bus-level ready
//   HWDATA, HWSTRB         write data phase; HWSTRB picks the byte lanes written
//   HRDATA                 read data, non-zero only in a read DONE cycle
//   HREADYOUT, HRESP       registered transfer-complete and response
module ahb_ext_mem_sub #(
  parameter int                  AHBW    = 64,
  parameter int                  PA_BITS = 34,
  parameter logic [PA_BITS-1:0]  BASE    = 34'h0_8000_0000,
  parameter int unsigned         RANGE   = 'h10000,
  parameter int                  WAIT    = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic                HREADY,
  input  logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW/8-1:0]   HWSTRB,
  output logic [AHBW-1:0]     HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP
);

  localparam int LANES     = AHBW / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int WORDS     = int'(RANGE) / LANES;
  localparam int IDX_BITS  = $clog2(WORDS);

  localparam logic [PA_BITS-1:0] RANGE_PA = PA_BITS'(RANGE);
  localparam logic [3:0]         WAIT_CNT = 4'(WAIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [IDX_BITS-1:0]   idx_q;
  logic                  wr_q;

  logic [AHBW-1:0]       mem [WORDS];

  // Address-phase decode
  logic [PA_BITS-1:0]    off;
  logic [PA_BITS-1:0]    align_mask;
  logic                  accept;
  logic                  in_range;
  logic                  size_ok;
  logic                  aligned;
  logic                  addr_err;

  assign off        = HADDR - BASE;
  assign accept     = HSEL && HREADY && HTRANS[1];
  // Lower bound checked on HADDR itself so an address below BASE cannot
  // wrap around into a small offset.
  assign in_range   = (HADDR >= BASE) && (off < RANGE_PA);
  assign size_ok    = (HSIZE <= 3'(LANE_BITS));
  assign align_mask = (PA_BITS'(1) << HSIZE) - PA_BITS'(1);
  assign aligned    = ((HADDR & align_mask) == '0);
  assign addr_err   = !(in_range && size_ok && aligned);

  // Only the word-index slice of the offset is stored; the rest is decode-only.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0], off};

  // Transfer FSM. HREADYOUT/HRESP are registered alongside the state so they
  // change only on clock edges (or asynchronously on reset).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          // cnt was loaded with WAIT on accept, so leaving at 1 gives
          // exactly WAIT low cycles.
          if (cnt <= 4'd1) begin
            state     <= ST_DONE;
            cnt       <= 4'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all drive HREADYOUT high, so a new address
          // phase can be taken here with no bubble.
          if (accept) begin
            idx_q <= off[LANE_BITS +: IDX_BITS];
            wr_q  <= HWRITE;
            if (addr_err) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_CNT != 4'd0) begin
              state     <= ST_WAIT;
              cnt       <= WAIT_CNT;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
            end else begin
              state     <= ST_DONE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array write at the edge that ends a write DONE. Not reset: contents
  // survive HRESETn, and reset forces IDLE asynchronously so an aborted
  // transfer can never reach this point.
  always_ff @(posedge HCLK) begin
    if (state == ST_DONE && wr_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (HWSTRB[i]) begin
          mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data is taken straight from the array during DONE, so a write that
  // committed on the edge entering this DONE is already visible.
  always_comb begin
    HRDATA = '0;
    if (state == ST_DONE && !wr_q) begin
      HRDATA = mem[idx_q];
    end
  end

endmodule

// File: tb/tb_ahb_ext_mem_sub.sv
// Directed table-driven bench for ahb_ext_mem_sub: one instance with one wait
// state, one with zero wait states; both share the bus inputs.
module tb_ahb_ext_mem_sub;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;

  localparam logic [33:0] A08  = 34'h0_8000_0008;
  localparam logic [33:0] A10  = 34'h0_8000_0010;
  localparam logic [33:0] A20  = 34'h0_8000_0020;
  localparam logic [33:0] ATOP = 34'h0_8000_FFF8;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2 = 64'hFFFF_FFFF_AAAA_BBBB;
  localparam logic [63:0] M2 = 64'h1122_3344_AAAA_BBBB;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] DT = 64'h0102_0304_0506_0708;
  localparam logic [63:0] V1 = 64'hA5A5_5A5A_1234_5678;
  localparam logic [63:0] V2 = 64'h0BAD_F00D_0BAD_F00D;
  localparam logic [63:0] V3 = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] V4 = 64'h7766_5544_3322_1100;
  localparam logic [63:0] V34 = 64'h7766_5544_0B0A_0908;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [33:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic [63:0] HWDATA;
  logic [7:0]  HWSTRB;

  logic [63:0] rdata_w1, rdata_w0;
  logic        rdy_w1, rdy_w0, resp_w1, resp_w0;

  int checks = 0;
  int errors = 0;
  int dut_sel = 0;   // 0: WAIT=1 instance, 1: WAIT=0 instance

  always #5 HCLK = ~HCLK;

  ahb_ext_mem_sub #(.WAIT(1)) u_w1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HREADY(HREADY), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HRDATA(rdata_w1), .HREADYOUT(rdy_w1), .HRESP(resp_w1)
  );

  ahb_ext_mem_sub #(.WAIT(0)) u_w0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HREADY(HREADY), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HRDATA(rdata_w0), .HREADYOUT(rdy_w0), .HRESP(resp_w0)
  );

  // One record per clock cycle: bus inputs driven for the coming edge and
  // the outputs expected during this cycle (before that edge).
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [33:0] addr;
    logic        rdy_in;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        exp_rdy;
    logic        exp_resp;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[$];
  vec_t seq_rst[$];
  vec_t seq_w0[$];

  function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                              logic [33:0] addr, logic rdy_in, logic [63:0] wdata,
                              logic [7:0] strb, logic er, logic ep, logic [63:0] ed);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.rdy_in = rdy_in; v.wdata = wdata; v.strb = strb;
    v.exp_rdy = er; v.exp_resp = ep; v.exp_data = ed;
    return v;
  endfunction

  // Idle bus cycle with the given HREADY and data-phase values.
  function automatic vec_t idl(logic rdy_in, logic [63:0] wdata, logic [7:0] strb,
                               logic er, logic ep, logic [63:0] ed);
    return mk(1'b0, T_IDLE, 1'b0, 3'd0, 34'h0, rdy_in, wdata, strb, er, ep, ed);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic er, logic ep, logic [63:0] ed);
    if (dut_sel == 0) begin
      chk({nm, ".rdy"},  64'(rdy_w1),  64'(er));
      chk({nm, ".resp"}, 64'(resp_w1), 64'(ep));
      chk({nm, ".data"}, rdata_w1, ed);
    end else begin
      chk({nm, ".rdy"},  64'(rdy_w0),  64'(er));
      chk({nm, ".resp"}, 64'(resp_w0), 64'(ep));
      chk({nm, ".data"}, rdata_w0, ed);
    end
  endtask

  // Called at a falling edge: check this cycle, drive the next address/data.
  task automatic apply(string nm, vec_t v);
    chk_out(nm, v.exp_rdy, v.exp_resp, v.exp_data);
    HSEL   = v.sel;
    HTRANS = v.trans;
    HWRITE = v.wr;
    HSIZE  = v.size;
    HADDR  = v.addr;
    HREADY = v.rdy_in;
    HWDATA = v.wdata;
    HWSTRB = v.strb;
    @(negedge HCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // WAIT=1 main table
    tbl.push_back(mk(1, T_NS,   1, 3, A08, 1, 64'h0, 8'h00, 1, 0, 64'h0)); // 0 IDLE, accept write
    tbl.push_back(mk(1, T_NS,   0, 3, A08, 0, D1, 8'hFF, 0, 0, 64'h0));    // 1 WAIT, bus held with HREADY low
    tbl.push_back(mk(1, T_NS,   0, 3, A08, 1, D1, 8'hFF, 1, 0, 64'h0));    // 2 DONE write, accept read
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 0, 64'h0));                      // 3 WAIT
    tbl.push_back(mk(1, T_NS,   1, 3, A08, 1, 64'h0, 8'h00, 1, 0, D1));    // 4 DONE read D1, accept write
    tbl.push_back(idl(0, D2, 8'h0F, 0, 0, 64'h0));                         // 5 WAIT
    tbl.push_back(mk(1, T_NS,   0, 3, A08, 1, D2, 8'h0F, 1, 0, 64'h0));    // 6 DONE partial write, accept read
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 0, 64'h0));                      // 7 WAIT
    tbl.push_back(mk(1, T_NS,   0, 3, 34'h0_7FFF_FFF8, 1, 64'h0, 8'h00, 1, 0, M2)); // 8 DONE merged, below BASE
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 1, 64'h0));                      // 9 ERR1
    tbl.push_back(mk(1, T_NS,   1, 2, 34'h0_8000_000A, 1, 64'h0, 8'h00, 1, 1, 64'h0)); // 10 ERR2, misaligned word
    tbl.push_back(idl(0, DB, 8'hFF, 0, 1, 64'h0));                         // 11 ERR1
    tbl.push_back(mk(1, T_NS,   1, 2, 34'h0_8000_0002, 1, DB, 8'hFF, 1, 1, 64'h0)); // 12 ERR2, misaligned word
    tbl.push_back(idl(0, DB, 8'hFF, 0, 1, 64'h0));                         // 13 ERR1
    tbl.push_back(mk(1, T_NS,   1, 4, A10, 1, DB, 8'hFF, 1, 1, 64'h0));    // 14 ERR2, oversize
    tbl.push_back(idl(0, DB, 8'hFF, 0, 1, 64'h0));                         // 15 ERR1
    tbl.push_back(mk(1, T_NS,   0, 3, A08, 1, DB, 8'hFF, 1, 1, 64'h0));    // 16 ERR2, accept read
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 0, 64'h0));                      // 17 WAIT
    tbl.push_back(mk(1, T_BUSY, 1, 3, A08, 1, DB, 8'hFF, 1, 0, M2));       // 18 DONE, errors wrote nothing
    tbl.push_back(mk(1, T_IDLE, 1, 3, A08, 1, DB, 8'hFF, 1, 0, 64'h0));    // 19 after BUSY: no transfer
    tbl.push_back(mk(0, T_NS,   1, 3, A08, 1, DB, 8'hFF, 1, 0, 64'h0));    // 20 after IDLE: no transfer
    tbl.push_back(mk(1, T_NS,   1, 3, A08, 0, DB, 8'hFF, 1, 0, 64'h0));    // 21 HSEL=0: no transfer
    tbl.push_back(mk(1, T_NS,   0, 3, A08, 1, DB, 8'hFF, 1, 0, 64'h0));    // 22 HREADY=0 ignored; accept read
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 0, 64'h0));                      // 23 WAIT
    tbl.push_back(idl(1, 64'h0, 8'h00, 1, 0, M2));                         // 24 DONE, still unchanged
    tbl.push_back(mk(1, T_NS,   1, 3, ATOP, 1, 64'h0, 8'h00, 1, 0, 64'h0)); // 25 IDLE, write last word
    tbl.push_back(idl(0, DT, 8'hFF, 0, 0, 64'h0));                         // 26 WAIT
    tbl.push_back(mk(1, T_NS,   0, 3, 34'h0_8001_0000, 1, DT, 8'hFF, 1, 0, 64'h0)); // 27 DONE, read past top
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 1, 64'h0));                      // 28 ERR1
    tbl.push_back(mk(1, T_NS,   0, 3, ATOP, 1, 64'h0, 8'h00, 1, 1, 64'h0)); // 29 ERR2, read last word
    tbl.push_back(idl(0, 64'h0, 8'h00, 0, 0, 64'h0));                      // 30 WAIT
    tbl.push_back(idl(1, 64'h0, 8'h00, 1, 0, DT));                         // 31 DONE last word
    tbl.push_back(idl(1, 64'h0, 8'h00, 1, 0, 64'h0));                      // 32 IDLE

    // Write V1, then begin a second write (V2) that reset aborts.
    seq_rst.push_back(mk(1, T_NS, 1, 3, A20, 1, 64'h0, 8'h00, 1, 0, 64'h0));
    seq_rst.push_back(idl(0, V1, 8'hFF, 0, 0, 64'h0));
    seq_rst.push_back(mk(1, T_NS, 1, 3, A20, 1, V1, 8'hFF, 1, 0, 64'h0));

    // WAIT=0: back-to-back write/read/write/read on one word.
    seq_w0.push_back(mk(1, T_NS, 1, 3, A10, 1, 64'h0, 8'h00, 1, 0, 64'h0));
    seq_w0.push_back(mk(1, T_NS, 0, 3, A10, 1, V3, 8'hFF, 1, 0, 64'h0));
    seq_w0.push_back(mk(1, T_NS, 1, 3, A10, 1, 64'h0, 8'h00, 1, 0, V3));
    seq_w0.push_back(mk(1, T_NS, 0, 3, A10, 1, V4, 8'hF0, 1, 0, 64'h0));
    seq_w0.push_back(idl(1, 64'h0, 8'h00, 1, 0, V34));
    seq_w0.push_back(idl(1, 64'h0, 8'h00, 1, 0, 64'h0));

    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = T_IDLE; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HREADY = 1'b1; HWDATA = '0; HWSTRB = '0;
    repeat (3) @(negedge HCLK);

    dut_sel = 0; chk_out("reset_w1", 1'b1, 1'b0, 64'h0);
    dut_sel = 1; chk_out("reset_w0", 1'b1, 1'b0, 64'h0);
    dut_sel = 0;
    HRESETn = 1'b1;   // first transfer goes out on the very next rising edge

    foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // Reset in the middle of a write wait state
    foreach (seq_rst[i]) apply($sformatf("rst_pre[%0d]", i), seq_rst[i]);
    chk_out("rst_wait", 1'b0, 1'b0, 64'h0);
    HSEL = 1'b0; HTRANS = T_IDLE; HREADY = 1'b0; HWDATA = V2; HWSTRB = 8'hFF;
    #2 HRESETn = 1'b0;
    #1 chk_out("rst_async", 1'b1, 1'b0, 64'h0);
    @(posedge HCLK);
    #1 chk_out("rst_held", 1'b1, 1'b0, 64'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    apply("rst_rd0", mk(1, T_NS, 0, 3, A20, 1, 64'h0, 8'h00, 1, 0, 64'h0));
    apply("rst_rd1", idl(0, 64'h0, 8'h00, 0, 0, 64'h0));
    apply("rst_rd2", idl(1, 64'h0, 8'h00, 1, 0, V1));
    apply("rst_rd3", idl(1, 64'h0, 8'h00, 1, 0, 64'h0));

    dut_sel = 1;
    foreach (seq_w0[i]) apply($sformatf("w0[%0d]", i), seq_w0[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
